macrocell_logic: RTL and testbench

- Parametrised successor to the single product term: P configurable AND terms over N inputs, an OR sum, polarity XOR and a macrocell register (D or T mode) with a product-term clear.
- Configuration is loaded through a serial shift chain and can be daisy-chained across macrocells.
- Sits in the MAX7000 simulation model between the programmable interconnect array and the I/O control block.

---
 rtl/macrocell_pkg.sv | 34 +++
 rtl/macrocell_if.sv | 25 ++
 rtl/macrocell_logic_masked_product_term.sv | 10 +
 rtl/macrocell_logic.sv | 81 ++++++++
 tb/tb_macrocell_logic.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/macrocell_pkg.sv
// Shared definitions for the macrocell: configuration layout helpers and register mode.
package macrocell_pkg;

  typedef enum logic {
    MODE_D = 1'b0,
    MODE_T = 1'b1
  } mode_e;

  // Layout: P*N mask bits, P term enables, then invert/bypass/toggle/pt0_clear.
  function automatic int config_length(input int n, input int p);
    return p * n + p + 4;
  endfunction

  function automatic int term_enable_offset(input int n, input int p);
    return p * n;
  endfunction

  function automatic int invert_offset(input int n, input int p);
    return p * n + p;
  endfunction

  function automatic int bypass_offset(input int n, input int p);
    return p * n + p + 1;
  endfunction

  function automatic int toggle_offset(input int n, input int p);
    return p * n + p + 2;
  endfunction

  function automatic int pt0_clear_offset(input int n, input int p);
    return p * n + p + 3;
  endfunction

endpackage

// File: rtl/macrocell_if.sv
// Macrocell signal bundle: array inputs, config chain and outputs.
interface macrocell_if #(
  parameter int N = 88,
  parameter int P = 5
);
  logic [N-1:0] input_signals;
  logic         clock_enable;
  logic         config_shift_enable;
  logic         config_data_in;
  logic         config_data_out;
  logic         config_loaded;
  logic [P-1:0] product_terms;
  logic         feedback_signal;
  logic         output_signal;

  modport master (
    output input_signals, clock_enable, config_shift_enable, config_data_in,
    input  config_data_out, config_loaded, product_terms, feedback_signal, output_signal
  );

  modport slave (
    input  input_signals, clock_enable, config_shift_enable, config_data_in,
    output config_data_out, config_loaded, product_terms, feedback_signal, output_signal
  );
endinterface

// File: rtl/macrocell_logic_masked_product_term.sv
// One AND term; a set mask bit removes that input from the product.
module masked_product_term #(
  parameter int N = 88
) (
  input  logic [N-1:0] inputs,
  input  logic [N-1:0] mask,
  output logic         term
);
  assign term = &(inputs | mask);
endmodule

// File: rtl/macrocell_logic.sv
// Macrocell: P masked product terms, OR sum, polarity, D/T register, serial config chain.
module macrocell_logic
  import macrocell_pkg::*;
#(
  parameter int input_signal_count = 88,
  parameter int product_term_count = 5
) (
  input logic        clock,
  input logic        reset,
  macrocell_if.slave bus
);
  localparam int N      = input_signal_count;
  localparam int P      = product_term_count;
  localparam int L      = config_length(N, P);
  localparam int CW     = $clog2(L + 1);
  localparam int TE_OFF = term_enable_offset(N, P);
  localparam int IV_OFF = invert_offset(N, P);
  localparam int BP_OFF = bypass_offset(N, P);
  localparam int TG_OFF = toggle_offset(N, P);
  localparam int PC_OFF = pt0_clear_offset(N, P);
  localparam logic [CW-1:0] FULL = CW'(L);

  logic [L-1:0]  cfg;
  logic [CW-1:0] count;
  logic          q;
  logic [P-1:0]  term, term_enable, sum_sel;
  logic          invert, bypass, pt0_clear, sum, comb, loaded, clear_hit;
  mode_e         mode;

  assign term_enable = cfg[TE_OFF +: P];
  assign invert      = cfg[IV_OFF];
  assign bypass      = cfg[BP_OFF];
  assign pt0_clear   = cfg[PC_OFF];
  assign mode        = cfg[TG_OFF] ? MODE_T : MODE_D;

  for (genvar p = 0; p < P; p++) begin : g_pt
    masked_product_term #(.N(N)) u_term (
      .inputs (bus.input_signals),
      .mask   (cfg[p*N +: N]),
      .term   (term[p])
    );
  end

  // With pt0_clear set, term 0 acts only as the register clear and leaves the sum.
  always_comb begin
    sum_sel = term & term_enable;
    if (pt0_clear) sum_sel[0] = 1'b0;
  end

  assign sum       = |sum_sel;
  assign comb      = sum ^ invert;
  assign clear_hit = pt0_clear & term[0] & term_enable[0];
  assign loaded    = (count == FULL);

  always_ff @(posedge clock) begin
    if (reset) begin
      cfg   <= '0;
      count <= '0;
    end else if (bus.config_shift_enable) begin
      cfg <= {bus.config_data_in, cfg[L-1:1]};
      if (!loaded) count <= count + CW'(1);
    end
  end

  // Shifting freezes the register so a partial config never clocks into q.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= 1'b0;
    end else if (!bus.config_shift_enable) begin
      if (clear_hit)              q <= 1'b0;
      else if (bus.clock_enable)  q <= (mode == MODE_T) ? (q ^ comb) : comb;
    end
  end

  assign bus.config_data_out = cfg[0];
  assign bus.config_loaded   = loaded;
  assign bus.product_terms   = term;
  assign bus.feedback_signal = q;
  assign bus.output_signal   = loaded ? (bypass ? comb : q) : 1'b0;

endmodule

// File: tb/tb_macrocell_logic.sv
// Bench for macrocell_logic at N=4, P=2: directed scenarios plus random traffic vs a bit-level model.
module tb_macrocell_logic;
  localparam int N = 4;
  localparam int P = 2;
  localparam int L = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] in_s = '0;
  logic ce = 1'b0, sh = 1'b0, din = 1'b0, shb = 1'b0;
  int checks = 0, failures = 0;

  // Reference state: config bits, load count and register value.
  logic [L-1:0] mcfg = '0;
  int           mcnt = 0;
  logic         mq   = 1'b0;

  always #5 clk = ~clk;

  macrocell_if #(.N(N), .P(P)) ifa ();
  macrocell_if #(.N(N), .P(P)) ifb ();

  assign ifa.input_signals       = in_s;
  assign ifa.clock_enable        = ce;
  assign ifa.config_shift_enable = sh;
  assign ifa.config_data_in      = din;
  assign ifb.input_signals       = in_s;
  assign ifb.clock_enable        = ce;
  assign ifb.config_shift_enable = shb;
  assign ifb.config_data_in      = ifa.config_data_out;

  macrocell_logic #(.input_signal_count(N), .product_term_count(P)) u_a (
    .clock(clk), .reset(rst), .bus(ifa.slave));
  macrocell_logic #(.input_signal_count(N), .product_term_count(P)) u_b (
    .clock(clk), .reset(rst), .bus(ifb.slave));

  function automatic logic m_term(input int p);
    for (int i = 0; i < N; i++)
      if (!mcfg[p*N+i] && !in_s[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_comb();
    logic s = 1'b0;
    for (int p = 0; p < P; p++)
      if (mcfg[P*N+p] && !(p == 0 && mcfg[P*N+P+3]) && m_term(p)) s = 1'b1;
    return s ^ mcfg[P*N+P];
  endfunction

  function automatic logic m_out();
    if (mcnt != L) return 1'b0;
    return mcfg[P*N+P+1] ? m_comb() : mq;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out",  {31'd0, ifa.output_signal},   {31'd0, m_out()});
    chk("fb",   {31'd0, ifa.feedback_signal}, {31'd0, mq});
    chk("ld",   {31'd0, ifa.config_loaded},   {31'd0, (mcnt == L)});
    chk("dout", {31'd0, ifa.config_data_out}, {31'd0, mcfg[0]});
    chk("pt",   {30'd0, ifa.product_terms},   {30'd0, m_term(1), m_term(0)});
  endtask

  // One clock: compute the model's next state from pre-edge inputs, then compare after the edge.
  task automatic cyc();
    logic [L-1:0] ncfg = mcfg;
    int           ncnt = mcnt;
    logic         nq   = mq;
    if (rst) begin
      ncfg = '0; ncnt = 0; nq = 1'b0;
    end else if (sh) begin
      ncfg = {din, mcfg[L-1:1]};
      if (ncnt < L) ncnt++;
    end else if (mcfg[P*N+P+3] && mcfg[P*N] && m_term(0)) begin
      nq = 1'b0;
    end else if (ce) begin
      nq = mcfg[P*N+P+2] ? (mq ^ m_comb()) : m_comb();
    end
    @(posedge clk);
    mcfg = ncfg; mcnt = ncnt; mq = nq;
    #1;
    check_all();
  endtask

  task automatic load(input logic [L-1:0] w);
    for (int k = 0; k < L; k++) begin
      din = w[k]; sh = 1'b1;
      cyc();
    end
    sh = 1'b0; din = 1'b0;
  endtask

  initial begin
    logic [L-1:0] wa, wb, wnew;
    logic [3:0]   tseq;

    // Reset state
    rst = 1'b1; cyc(); cyc();
    chk("rst_out", {31'd0, ifa.output_signal}, 32'd0);
    chk("rst_ld",  {31'd0, ifa.config_loaded}, 32'd0);
    chk("rst_dout", {31'd0, ifa.config_data_out}, 32'd0);
    rst = 1'b0;

    // D mode, term0 = in[0]&in[1]; loaded must rise only on the 14th shift
    for (int k = 0; k < L; k++) begin
      din = k[0] ? 1'b0 : 1'b0;
      wa = 14'h010C; din = wa[k]; sh = 1'b1;
      cyc();
      chk("ld_edge", {31'd0, ifa.config_loaded}, {31'd0, (k == L - 1)});
    end
    sh = 1'b0;
    in_s = 4'b0011; ce = 1'b1; cyc();
    chk("d_hi", {31'd0, ifa.output_signal}, 32'd1);
    in_s = 4'b0001; cyc();
    chk("d_lo", {31'd0, ifa.output_signal}, 32'd0);
    ce = 1'b0;

    // Bypass + invert: combinational !(in0&in1)
    load(14'h0D0C);
    for (int k = 0; k < 8; k++) begin
      in_s = 4'($urandom); #1;
      chk("byp", {31'd0, ifa.output_signal}, {31'd0, !(in_s[0] & in_s[1])});
      cyc();
    end

    // Toggle mode with an always-true sum
    load(14'h12F0);
    chk("tgl_q0", {31'd0, ifa.feedback_signal}, 32'd0);
    tseq = 4'b0101; ce = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("tgl", {31'd0, ifa.feedback_signal}, {31'd0, tseq[k]});
    end
    ce = 1'b0; cyc(); cyc();
    chk("tgl_hold", {31'd0, ifa.feedback_signal}, 32'd0);

    // pt0_clear: term0 = in[3] clears q regardless of clock_enable
    load(14'h23F7);
    in_s = 4'b0000; ce = 1'b1; cyc();
    chk("clr_set", {31'd0, ifa.feedback_signal}, 32'd1);
    in_s = 4'b1000; ce = 1'b0; cyc();
    chk("clr_hit", {31'd0, ifa.feedback_signal}, 32'd0);
    ce = 1'b1; cyc();
    chk("clr_pri", {31'd0, ifa.feedback_signal}, 32'd0);
    in_s = 4'b0000; cyc();
    chk("clr_rel", {31'd0, ifa.output_signal}, 32'd1);
    ce = 1'b0;

    // Random loads and traffic, including shifts racing clock_enable and stray resets
    for (int it = 0; it < 20; it++) begin
      ce = 1'($urandom);
      load(14'($urandom));
      for (int k = 0; k < 15; k++) begin
        in_s = 4'($urandom);
        ce   = 1'($urandom);
        sh   = ($urandom_range(0, 7) == 0);
        din  = 1'($urandom);
        rst  = ($urandom_range(0, 49) == 0);
        cyc();
      end
      rst = 1'b0; sh = 1'b0;
    end

    // Daisy chain: first 14 bits end in B, last 14 in A
    rst = 1'b1; cyc(); rst = 1'b0;
    wa = 14'($urandom); wb = 14'($urandom);
    shb = 1'b1;
    for (int k = 0; k < 2 * L; k++) begin
      din = (k < L) ? wb[k] : wa[k-L]; sh = 1'b1;
      cyc();
    end
    sh = 1'b0; shb = 1'b0;
    chk("chain_a", {18'd0, u_a.cfg}, {18'd0, wa});
    chk("chain_b", {18'd0, u_b.cfg}, {18'd0, wb});
    chk("chain_lda", {31'd0, ifa.config_loaded}, 32'd1);
    chk("chain_ldb", {31'd0, ifb.config_loaded}, 32'd1);

    // Reset mid-load aborts; a full new load is required
    rst = 1'b1; cyc(); rst = 1'b0;
    wa = 14'h3FFF;
    for (int k = 0; k < 7; k++) begin
      din = wa[k]; sh = 1'b1; cyc();
      chk("abort_out", {31'd0, ifa.output_signal}, 32'd0);
    end
    rst = 1'b1; cyc(); rst = 1'b0;
    wnew = 14'h0A5C;
    for (int k = 0; k < L; k++) begin
      din = wnew[k]; sh = 1'b1; cyc();
      chk("reload_ld", {31'd0, ifa.config_loaded}, {31'd0, (k == L - 1)});
      if (k < L - 1) chk("reload_out", {31'd0, ifa.output_signal}, 32'd0);
    end
    sh = 1'b0;
    chk("reload_cfg", {18'd0, u_a.cfg}, {18'd0, wnew});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
